// File: rtl/line_access_responder_if.sv
// Line memory interface of the line access responder: the whole-line requester side
// and the narrower word bus side, bundled so the responder has a single port.
interface line_access_responder_if #(
    parameter int unsigned LineWidth    = 128,
    parameter int unsigned WordWidth    = 32,
    parameter int unsigned MemAddrWidth = 28
);
    localparam int unsigned BeatCount    = LineWidth / WordWidth;
    localparam int unsigned BusAddrWidth = MemAddrWidth + $clog2(BeatCount);

    // Requester (TLB replacer) side
    logic [MemAddrWidth-1:0] memAddr;
    logic                    memReadEnable;
    logic                    memWriteEnable;
    logic [LineWidth-1:0]    memWriteValue;
    logic                    memReadDone;
    logic                    memWriteDone;
    logic [LineWidth-1:0]    memReadValue;

    // Word bus (arbiter) side
    logic                    busReqValid;
    logic                    busReqReady;
    logic                    busReqWrite;
    logic [BusAddrWidth-1:0] busReqAddr;
    logic [WordWidth-1:0]    busReqWdata;
    logic                    busRspValid;
    logic [WordWidth-1:0]    busRspData;

    // Responder view
    modport slave (
        input  memAddr, memReadEnable, memWriteEnable, memWriteValue,
        output memReadDone, memWriteDone, memReadValue,
        output busReqValid, busReqWrite, busReqAddr, busReqWdata,
        input  busReqReady, busRspValid, busRspData
    );

    // Environment view: requester plus memory bus
    modport master (
        output memAddr, memReadEnable, memWriteEnable, memWriteValue,
        input  memReadDone, memWriteDone, memReadValue,
        input  busReqValid, busReqWrite, busReqAddr, busReqWdata,
        output busReqReady, busRspValid, busRspData
    );
endinterface

// File: rtl/line_access_responder.sv
// Line access responder: services whole-line read/write requests as a sequence of
// word beats on the core memory bus. Reads are pipelined (all beats may be issued
// before any response returns); writes finish when the last beat is accepted.
module line_access_responder #(
    parameter int unsigned LineWidth    = 128,
    parameter int unsigned WordWidth    = 32,
    parameter int unsigned MemAddrWidth = 28
) (
    input logic                    clk,
    input logic                    rst,
    line_access_responder_if.slave lif
);
    localparam int unsigned BeatCount = LineWidth / WordWidth;
    localparam int unsigned IdxWidth  = $clog2(BeatCount);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(BeatCount - 1);
    localparam logic [IdxWidth-1:0] OneIdx  = IdxWidth'(1);

    localparam logic [2:0] StIdle       = 3'd0;
    localparam logic [2:0] StReadIssue  = 3'd1;
    localparam logic [2:0] StReadWait   = 3'd2;
    localparam logic [2:0] StWriteIssue = 3'd3;
    localparam logic [2:0] StDone       = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [MemAddrWidth-1:0] addr_q, addr_d;
    logic [LineWidth-1:0]    wline_q, wline_d;
    logic [LineWidth-1:0]    rline_q, rline_d;
    logic [IdxWidth-1:0]     issue_idx_q, issue_idx_d;
    logic [IdxWidth-1:0]     rsp_idx_q, rsp_idx_d;
    logic                    is_write_q, is_write_d;

    logic req_fire;
    logic rsp_take;
    logic last_issue;
    logic last_rsp;

    // Bus request fields come only from latched state, so they hold while stalled.
    always_comb begin
        lif.busReqValid = 1'b0;
        lif.busReqWrite = 1'b0;
        lif.busReqAddr  = '0;
        lif.busReqWdata = '0;
        case (state_q)
            StReadIssue: begin
                lif.busReqValid = 1'b1;
                lif.busReqAddr  = {addr_q, issue_idx_q};
            end
            StWriteIssue: begin
                lif.busReqValid = 1'b1;
                lif.busReqWrite = 1'b1;
                lif.busReqAddr  = {addr_q, issue_idx_q};
                lif.busReqWdata = wline_q[issue_idx_q*WordWidth +: WordWidth];
            end
            default: ;
        endcase
    end

    assign lif.memReadDone  = (state_q == StDone) && !is_write_q;
    assign lif.memWriteDone = (state_q == StDone) && is_write_q;
    assign lif.memReadValue = rline_q;

    // Next-state, beat counters and read-line assembly.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wline_d     = wline_q;
        rline_d     = rline_q;
        issue_idx_d = issue_idx_q;
        rsp_idx_d   = rsp_idx_q;
        is_write_d  = is_write_q;

        req_fire   = lif.busReqValid && lif.busReqReady;
        // Responses only mean something while a read is in flight.
        rsp_take   = lif.busRspValid && ((state_q == StReadIssue) || (state_q == StReadWait));
        last_issue = req_fire && (issue_idx_q == LastIdx);
        last_rsp   = rsp_take && (rsp_idx_q == LastIdx);

        if (req_fire) begin
            issue_idx_d = issue_idx_q + OneIdx;
        end
        if (rsp_take) begin
            rline_d[rsp_idx_q*WordWidth +: WordWidth] = lif.busRspData;
            rsp_idx_d = rsp_idx_q + OneIdx;
        end

        case (state_q)
            StIdle: begin
                // Read wins when both enables are high; a held write is taken afterwards.
                if (lif.memReadEnable) begin
                    addr_d      = lif.memAddr;
                    issue_idx_d = '0;
                    rsp_idx_d   = '0;
                    is_write_d  = 1'b0;
                    state_d     = StReadIssue;
                end else if (lif.memWriteEnable) begin
                    addr_d      = lif.memAddr;
                    wline_d     = lif.memWriteValue;
                    issue_idx_d = '0;
                    rsp_idx_d   = '0;
                    is_write_d  = 1'b1;
                    state_d     = StWriteIssue;
                end
            end
            StReadIssue: begin
                if (last_issue) begin
                    state_d = last_rsp ? StDone : StReadWait;
                end
            end
            StReadWait: begin
                if (last_rsp) begin
                    state_d = StDone;
                end
            end
            StWriteIssue: begin
                if (last_issue) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; synchronous reset aborts any transaction without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wline_q     <= '0;
            rline_q     <= '0;
            issue_idx_q <= '0;
            rsp_idx_q   <= '0;
            is_write_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wline_q     <= wline_d;
            rline_q     <= rline_d;
            issue_idx_q <= issue_idx_d;
            rsp_idx_q   <= rsp_idx_d;
            is_write_q  <= is_write_d;
        end
    end
endmodule

// File: tb/tb_line_access_responder.sv
// Bench for line_access_responder: directed cases plus randomized line traffic,
// checked through an expected-transaction queue and an expected-beat queue.
module tb_line_access_responder;
    localparam int unsigned LW  = 128;
    localparam int unsigned WW  = 32;
    localparam int unsigned MAW = 28;
    localparam int unsigned BC  = LW / WW;
    localparam int unsigned IW  = $clog2(BC);
    localparam int unsigned BAW = MAW + IW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    line_access_responder_if #(.LineWidth(LW), .WordWidth(WW), .MemAddrWidth(MAW)) lif ();

    line_access_responder #(.LineWidth(LW), .WordWidth(WW), .MemAddrWidth(MAW)) dut (
        .clk (clk),
        .rst (rst),
        .lif (lif)
    );

    typedef struct {
        bit          is_write;
        logic [LW-1:0] line;
        int          set_cyc;
        int          lat;
    } txn_t;

    typedef struct {
        bit             wr;
        logic [BAW-1:0] addr;
        logic [WW-1:0]  data;
    } beat_t;

    typedef struct {
        logic [WW-1:0] data;
        int            due;
    } rsp_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int last_rsp_cyc = -100;

    txn_t  exp_q[$];
    beat_t beat_q[$];
    rsp_t  rsp_q[$];

    logic [WW-1:0] bus_mem [logic [BAW-1:0]];
    logic [LW-1:0] ref_mem [logic [MAW-1:0]];
    logic [LW-1:0] last_read_line = '0;

    int ready_mode    = 0;
    int rsp_extra_min = 0;
    int rsp_extra_max = 0;
    int rsp_gap       = 0;
    bit spur_req      = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic logic [WW-1:0] init_word(input logic [BAW-1:0] a);
        return (WW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [WW-1:0] bus_word(input logic [BAW-1:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return init_word(a);
    endfunction

    // Reference memory holds whole lines; untouched lines default to the bus' initial content.
    function automatic logic [LW-1:0] ref_line(input logic [MAW-1:0] a);
        logic [LW-1:0] l;
        if (ref_mem.exists(a)) return ref_mem[a];
        for (int i = 0; i < BC; i++) l[i*WW +: WW] = init_word({a, IW'(i)});
        return l;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < BC; i++) l[i*WW +: WW] = $urandom;
        return l;
    endfunction

    // Memory bus model: responses first, then the ready decision for the coming edge.
    initial begin
        logic  rdy;
        bit    prev_stall;
        beat_t prev;
        beat_t cur;
        rdy = 1'b1;
        prev_stall = 1'b0;
        lif.busReqReady = 1'b0;
        lif.busRspValid = 1'b0;
        lif.busRspData  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                rsp_q.delete();
                lif.busReqReady = 1'b0;
                lif.busRspValid = 1'b0;
                lif.busRspData  = '0;
                prev_stall = 1'b0;
                continue;
            end
            lif.busRspValid = 1'b0;
            lif.busRspData  = '0;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc && cyc >= last_rsp_cyc + 1 + rsp_gap) begin
                lif.busRspValid = 1'b1;
                lif.busRspData  = rsp_q[0].data;
                void'(rsp_q.pop_front());
                last_rsp_cyc = cyc;
            end else if (spur_req) begin
                lif.busRspValid = 1'b1;
                lif.busRspData  = 32'hDEAD_BEEF;
                spur_req = 1'b0;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = ~rdy;
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            lif.busReqReady = rdy;
            if (lif.busReqValid) begin
                cur.wr   = lif.busReqWrite;
                cur.addr = lif.busReqAddr;
                cur.data = lif.busReqWrite ? lif.busReqWdata : '0;
                if (prev_stall)
                    check("req_hold", {cur.wr, cur.addr, cur.data}, {prev.wr, prev.addr, prev.data});
                if (beat_q.size() == 0) begin
                    fail("beat", "bus request with no beat expected");
                end else begin
                    check("beat", {cur.wr, cur.addr, cur.data},
                          {beat_q[0].wr, beat_q[0].addr, beat_q[0].data});
                    if (rdy) begin
                        void'(beat_q.pop_front());
                        acc_cnt++;
                        if (cur.wr) begin
                            bus_mem[cur.addr] = lif.busReqWdata;
                        end else begin
                            rsp_q.push_back('{data: bus_word(cur.addr),
                                              due: cyc + 1 + $urandom_range(rsp_extra_min, rsp_extra_max)});
                        end
                    end
                end
                prev_stall = !rdy;
                prev = cur;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Completion monitor: every done pulse must match the oldest expected transaction.
    initial forever begin
        txn_t t;
        @(negedge clk);
        #2;
        if (lif.memReadDone || lif.memWriteDone) begin
            if (lif.memReadDone && lif.memWriteDone) begin
                fail("done", "read and write done together");
            end else if (exp_q.size() == 0) begin
                fail("done", "unexpected done pulse");
            end else begin
                t = exp_q.pop_front();
                check("done_is_write", LW'(lif.memWriteDone), LW'(t.is_write));
                if (!t.is_write) begin
                    check("read_line", lif.memReadValue, t.line);
                    check("read_done_after_last_rsp", LW'(cyc - last_rsp_cyc), LW'(1));
                end
                if (t.lat >= 0) check("latency", LW'(cyc - t.set_cyc), LW'(t.lat));
            end
        end
    end

    task automatic push_beats(input bit wr, input logic [MAW-1:0] a, input logic [LW-1:0] l);
        for (int i = 0; i < BC; i++)
            beat_q.push_back('{wr: wr, addr: {a, IW'(i)}, data: wr ? l[i*WW +: WW] : '0});
    endtask

    task automatic issue_read(input logic [MAW-1:0] a, input int lat);
        lif.memAddr = a;
        lif.memReadEnable = 1'b1;
        push_beats(1'b0, a, '0);
        exp_q.push_back('{is_write: 1'b0, line: ref_line(a), set_cyc: cyc, lat: lat});
        last_read_line = ref_line(a);
    endtask

    task automatic issue_write(input logic [MAW-1:0] a, input logic [LW-1:0] l, input int lat);
        lif.memAddr = a;
        lif.memWriteValue = l;
        lif.memWriteEnable = 1'b1;
        push_beats(1'b1, a, l);
        exp_q.push_back('{is_write: 1'b1, line: l, set_cyc: cyc, lat: lat});
        ref_mem[a] = l;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(lif.memReadDone || lif.memWriteDone) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail(name, "timeout waiting for done");
    endtask

    task automatic do_read(input logic [MAW-1:0] a, input int lat);
        issue_read(a, lat);
        wait_done("read");
        lif.memReadEnable = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [MAW-1:0] a, input logic [LW-1:0] l, input int lat);
        issue_write(a, l, lat);
        wait_done("write");
        lif.memWriteEnable = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_req_valid"}, LW'(lif.busReqValid), '0);
        check({name, "_req_write"}, LW'(lif.busReqWrite), '0);
        check({name, "_req_addr"}, LW'(lif.busReqAddr), '0);
        check({name, "_dones"}, LW'({lif.memReadDone, lif.memWriteDone}), '0);
        check({name, "_read_value"}, lif.memReadValue, '0);
    endtask

    initial begin
        int a0;
        int n;
        lif.memAddr = '0;
        lif.memReadEnable = 1'b0;
        lif.memWriteEnable = 1'b0;
        lif.memWriteValue = '0;
        for (int i = 0; i < BC; i++) bus_mem[{MAW'('h123), IW'(i)}] = 32'h1111_1111 * (i + 1);
        ref_mem[MAW'('h123)] = 128'h44444444_33333333_22222222_11111111;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Minimum-latency read of a known line
        do_read(MAW'('h123), BC + 2);

        // Write with toggling ready, then minimum-latency write
        ready_mode = 1;
        do_write(MAW'('h10), 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, -1);
        ready_mode = 0;
        do_write(MAW'('h55), rand_line(), BC + 1);

        // All beats issued before any response, then responses two cycles apart
        rsp_extra_min = 4;
        rsp_extra_max = 4;
        rsp_gap = 2;
        do_read(MAW'('h10), -1);
        rsp_extra_min = 0;
        rsp_extra_max = 0;
        rsp_gap = 0;

        // Both enables high: read first, then the still-held write
        lif.memWriteValue = rand_line();
        issue_read(MAW'('h77), BC + 2);
        issue_write(MAW'('h77), lif.memWriteValue, -1);
        wait_done("both_read");
        lif.memReadEnable = 1'b0;
        @(negedge clk);
        wait_done("both_write");
        lif.memWriteEnable = 1'b0;
        @(negedge clk);
        do_read(MAW'('h77), BC + 2);

        // Reset after two read beats: abort with no done pulse
        a0 = acc_cnt;
        issue_read(MAW'('h123), -1);
        n = 0;
        while (acc_cnt < a0 + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("reset_mid", "timeout waiting for two beats");
        rst = 1'b1;
        lif.memReadEnable = 1'b0;
        beat_q.delete();
        void'(exp_q.pop_back());
        @(negedge clk);
        check_idle_outputs("reset_mid");
        rst = 1'b0;
        last_read_line = '0;
        @(negedge clk);
        do_read(MAW'('h123), BC + 2);

        // Spurious response while idle must be ignored
        repeat (2) @(negedge clk);
        spur_req = 1'b1;
        repeat (4) @(negedge clk);
        check("spurious_rsp", lif.memReadValue, last_read_line);

        // Randomized traffic over a small address window
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            rsp_extra_min = 0;
            rsp_extra_max = $urandom_range(0, 3);
            rsp_gap = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 0) do_read(MAW'($urandom_range(0, 7)), -1);
            else do_write(MAW'($urandom_range(0, 7)), rand_line(), -1);
        end

        repeat (5) @(negedge clk);
        check("exp_queue_empty", LW'(exp_q.size()), '0);
        check("beat_queue_empty", LW'(beat_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
